// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The stage connects through the slave modport; the driving side uses master.
interface if_stage_if #(
   parameter int NB_PC       = 32,
   parameter int NB_INSTR    = 32,
   parameter int NB_MEM_ADDR = 10,
   parameter int NB_COUNT    = 32
);
   logic                   i_valid;
   logic                   i_hazard;
   logic                   i_branch_taken;
   logic [NB_PC-1:0]       i_branch_addr;
   logic [NB_MEM_ADDR-1:0] o_imem_addr;
   logic [NB_INSTR-1:0]    i_imem_data;
   logic [NB_INSTR-1:0]    o_instr;
   logic [NB_PC-1:0]       o_pc_next;
   logic [NB_PC-1:0]       o_pc;
   logic                   o_halted;
   logic [NB_COUNT-1:0]    o_fetch_count;

   modport slave (
      input  i_valid, i_hazard, i_branch_taken, i_branch_addr, i_imem_data,
      output o_imem_addr, o_instr, o_pc_next, o_pc, o_halted, o_fetch_count
   );

   modport master (
      output i_valid, i_hazard, i_branch_taken, i_branch_addr, i_imem_data,
      input  o_imem_addr, o_instr, o_pc_next, o_pc, o_halted, o_fetch_count
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register,
// sticky HALT detection and a fetched-instruction counter for debug.
module if_stage #(
   parameter int                   NB_PC       = 32,
   parameter int                   NB_INSTR    = 32,
   parameter int                   NB_MEM_ADDR = 10,
   parameter logic [NB_PC-1:0]     RESET_PC    = '0,
   parameter logic [NB_INSTR-1:0]  HALT_INSTR  = 32'hFFFFFFFF,
   parameter int                   NB_COUNT    = 32
) (
   input  logic         i_clock,
   input  logic         i_reset,
   if_stage_if.slave    bus
);

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [NB_PC-1:0]      r_pc;
   logic [NB_PC-1:0]      w_pc_next_val;
   logic [NB_INSTR-1:0]   r_instr;
   logic [NB_INSTR-1:0]   w_instr_next;
   logic [NB_PC-1:0]      r_pc_plus4;
   logic [NB_PC-1:0]      w_pc_plus4_next;
   logic [NB_COUNT-1:0]   r_count;
   logic [NB_COUNT-1:0]   w_count_next;
   logic [NB_PC-1:0]      w_pc_inc;

   assign w_pc_inc = r_pc + NB_PC'(4);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= RUN;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_pc_plus4 <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next_val;
         r_instr    <= w_instr_next;
         r_pc_plus4 <= w_pc_plus4_next;
         r_count    <= w_count_next;
      end
   end

   // Stall outranks redirect because branch operands are not valid during a stall;
   // a redirect always flushes IF/ID, which also discards a HALT being fetched.
   always_comb begin
      w_state_next    = r_state;
      w_pc_next_val   = r_pc;
      w_instr_next    = r_instr;
      w_pc_plus4_next = r_pc_plus4;
      w_count_next    = r_count;
      if (bus.i_valid && !bus.i_hazard) begin
         if (bus.i_branch_taken) begin
            w_pc_next_val   = {bus.i_branch_addr[NB_PC-1:2], 2'b00};
            w_instr_next    = '0;
            w_pc_plus4_next = '0;
         end else if (r_state == HALTED) begin
            w_instr_next    = '0;
            w_pc_plus4_next = '0;
         end else begin
            w_instr_next    = bus.i_imem_data;
            w_pc_plus4_next = w_pc_inc;
            w_count_next    = r_count + NB_COUNT'(1);
            if (bus.i_imem_data == HALT_INSTR) begin
               w_state_next = HALTED;
            end else begin
               w_pc_next_val = w_pc_inc;
            end
         end
      end
   end

   assign bus.o_imem_addr   = r_pc[NB_MEM_ADDR+1:2];
   assign bus.o_pc          = r_pc;
   assign bus.o_instr       = r_instr;
   assign bus.o_pc_next     = r_pc_plus4;
   assign bus.o_halted      = (r_state == HALTED);
   assign bus.o_fetch_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, priority,
// freeze, asynchronous reset and HALT behaviour against hand-computed values.
module tb_if_stage;

   localparam logic [31:0] HALT = 32'hFFFFFFFF;

   logic        clock;
   logic        reset;
   logic [31:0] mem [0:1023];
   int          testsRun;
   int          testsFailed;
   logic [31:0] keepPc;
   logic [31:0] keepInstr;
   logic [31:0] keepCount;

   if_stage_if #(.NB_PC(32), .NB_INSTR(32), .NB_MEM_ADDR(10), .NB_COUNT(32)) bus ();

   if_stage #(
      .NB_PC(32), .NB_INSTR(32), .NB_MEM_ADDR(10),
      .RESET_PC(32'h0), .HALT_INSTR(32'hFFFFFFFF), .NB_COUNT(32)
   ) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   assign bus.i_imem_data = mem[bus.o_imem_addr];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive the control inputs, then advance the given number of rising edges.
   task automatic applyStimulus(input logic valid, input logic hazard,
                                input logic branch, input logic [31:0] addr,
                                input int edges);
      bus.i_valid        = valid;
      bus.i_hazard       = hazard;
      bus.i_branch_taken = branch;
      bus.i_branch_addr  = addr;
      repeat (edges) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pcNext,
                             input logic [31:0] count, input logic halted);
      checkOutput({tag, ".pc"}, bus.o_pc, pc);
      checkOutput({tag, ".imem_addr"}, {22'd0, bus.o_imem_addr}, {22'd0, pc[11:2]});
      checkOutput({tag, ".instr"}, bus.o_instr, instr);
      checkOutput({tag, ".pc_next"}, bus.o_pc_next, pcNext);
      checkOutput({tag, ".count"}, bus.o_fetch_count, count);
      checkOutput({tag, ".halted"}, {31'd0, bus.o_halted}, {31'd0, halted});
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      for (int k = 0; k < 1024; k++) mem[k] = 32'h1000 + k;
      bus.i_valid        = 1'b1;
      bus.i_hazard       = 1'b0;
      bus.i_branch_taken = 1'b0;
      bus.i_branch_addr  = 32'h0;
      reset = 1'b0;
      #1;
      checkState("reset", 32'h0, 32'h0, 32'h0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2);
      checkState("reset_held", 32'h0, 32'h0, 32'h0, 32'd0, 1'b0);
      reset = 1'b1;

      // Sequential fetch
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("fetch1", 32'h4, 32'h1000, 32'h4, 32'd1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("fetch2", 32'h8, 32'h1001, 32'h8, 32'd2, 1'b0);

      // Stall for two edges at PC=8, then release
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkState("stall1", 32'h8, 32'h1001, 32'h8, 32'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkState("stall2", 32'h8, 32'h1001, 32'h8, 32'd2, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("stall_release", 32'hC, 32'h1002, 32'hC, 32'd3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("fetch4", 32'h10, 32'h1003, 32'h10, 32'd4, 1'b0);

      // Stall wins over a simultaneous redirect
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h43, 1);
      checkState("prio_hold", 32'h10, 32'h1003, 32'h10, 32'd4, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h43, 1);
      checkState("redirect", 32'h40, 32'h0, 32'h0, 32'd4, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("redirect_target", 32'h44, 32'h1010, 32'h44, 32'd5, 1'b0);

      // Freeze for three edges
      keepPc    = bus.o_pc;
      keepInstr = bus.o_instr;
      keepCount = bus.o_fetch_count;
      for (int e = 0; e < 3; e++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1);
         checkState("freeze", 32'h44, 32'h1010, 32'h44, 32'd5, 1'b0);
      end
      checkOutput("freeze_pc_const", bus.o_pc, keepPc);
      checkOutput("freeze_instr_const", bus.o_instr, keepInstr);
      checkOutput("freeze_count_const", bus.o_fetch_count, keepCount);

      // HALT on the memory bus during a redirect is discarded
      mem[17] = HALT;
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 1);
      checkState("halt_in_redirect", 32'h80, 32'h0, 32'h0, 32'd5, 1'b0);
      mem[17] = 32'h1011;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("after_redirect80", 32'h84, 32'h1020, 32'h84, 32'd6, 1'b0);

      // Asynchronous reset mid-cycle, then restart from RESET_PC
      #2;
      reset = 1'b0;
      #1;
      checkState("async_reset", 32'h0, 32'h0, 32'h0, 32'd0, 1'b0);
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("restart", 32'h4, 32'h1000, 32'h4, 32'd1, 1'b0);

      // HALT at word 3
      mem[3] = HALT;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 3);
      checkState("pre_halt", 32'hC, 32'h1002, 32'hC, 32'd3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("halt_captured", 32'hC, HALT, 32'h10, 32'd4, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkState("halt_stalled", 32'hC, HALT, 32'h10, 32'd4, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("halted_nop", 32'hC, 32'h0, 32'h0, 32'd4, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2);
      checkState("halted_frozen", 32'hC, 32'h0, 32'h0, 32'd4, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h22, 1);
      checkState("halted_redirect", 32'h20, 32'h0, 32'h0, 32'd4, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkState("halted_after_redir", 32'h20, 32'h0, 32'h0, 32'd4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
